// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the stage sequencer and the control unit it feeds:
// stage and state encodings plus program-memory geometry.
package stage_sequencer_pkg;

  localparam int unsigned PADDR_W = 8;
  localparam int unsigned INSTR_W = 12;

  localparam logic [PADDR_W-1:0] PADDR_LAST = '1;

  typedef enum logic [1:0] {
    STAGE_LOAD    = 2'b00,
    STAGE_FETCH   = 2'b01,
    STAGE_DECODE  = 2'b10,
    STAGE_EXECUTE = 2'b11
  } stage_t;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_EXECUTE = 3'b011,
    ST_HALT    = 3'b100
  } seq_state_t;

  // HALT reports the LOAD stage code so the control unit sees it as idle.
  function automatic stage_t stage_of(seq_state_t s);
    case (s)
      ST_FETCH:   return STAGE_FETCH;
      ST_DECODE:  return STAGE_DECODE;
      ST_EXECUTE: return STAGE_EXECUTE;
      default:    return STAGE_LOAD;
    endcase
  endfunction

endpackage

// File: rtl/stage_sequencer_load_addr_counter.sv
// Program-memory load address: clearable 8-bit up-counter that saturates
// at the last address and flags it, so the load never wraps.
module load_addr_counter
  import stage_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [PADDR_W-1:0] count,
  output logic               tc
);

  assign tc = (count == PADDR_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Processor stage sequencer: loads the program image, then cycles
// FETCH/DECODE/EXECUTE with halt, single-step and restart control.
module stage_sequencer
  import stage_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  input  logic [INSTR_W-1:0]  load_data,
  input  logic                load_last,
  output logic                load_ready,
  output logic [PADDR_W-1:0]  pmem_addr,
  output logic [INSTR_W-1:0]  pmem_wdata,
  output logic                pmem_we,
  input  logic                run_en,
  input  logic                halt_req,
  input  logic                step_req,
  input  logic                restart_req,
  output logic [1:0]          stage,
  output logic                core_en,
  output logic                halted,
  output logic [15:0]         instr_count
);

  seq_state_t state, state_nxt;
  logic       step_mode, step_mode_nxt;
  logic       accept;
  logic       restart;
  logic       addr_tc;

  assign load_ready = (state == ST_LOAD);
  assign accept     = load_valid && load_ready;
  assign restart    = (state == ST_HALT) && restart_req;

  assign pmem_we    = accept;
  assign pmem_wdata = load_data;

  load_addr_counter u_addr (
    .clk   (clk),
    .rst   (rst),
    .clr   (restart),
    .inc   (accept),
    .count (pmem_addr),
    .tc    (addr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      step_mode <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_mode <= step_mode_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      instr_count <= '0;
    end else if (state == ST_EXECUTE) begin
      instr_count <= instr_count + 16'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    step_mode_nxt = step_mode;
    case (state)
      ST_LOAD: begin
        if (accept && (load_last || addr_tc)) begin
          state_nxt     = run_en ? ST_FETCH : ST_HALT;
          step_mode_nxt = 1'b0;
        end
      end
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXECUTE;
      ST_EXECUTE: begin
        if (step_mode || halt_req || !run_en) begin
          state_nxt     = ST_HALT;
          step_mode_nxt = 1'b0;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (restart_req) begin
          state_nxt     = ST_LOAD;
          step_mode_nxt = 1'b0;
        end else if (step_req) begin
          state_nxt     = ST_FETCH;
          step_mode_nxt = 1'b1;
        end else if (run_en && !halt_req) begin
          state_nxt     = ST_FETCH;
          step_mode_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt     = ST_LOAD;
        step_mode_nxt = 1'b0;
      end
    endcase
  end

  assign stage   = stage_of(state);
  assign core_en = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXECUTE);
  assign halted  = (state == ST_HALT);

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port load_valid, input, 1 bit: program word offered.
REQ-004 SHALL have port load_data, input, 12 bits: program word.
REQ-005 SHALL have port load_last, input, 1 bit: offered word is the final program word.
REQ-006 SHALL have port load_ready, output, 1 bit: sequencer accepts a program word this cycle.
REQ-007 SHALL have port pmem_addr, output, 8 bits: program-memory write address during LOAD.
REQ-008 SHALL have port pmem_wdata, output, 12 bits: load_data forwarded to program memory.
REQ-009 SHALL have port pmem_we, output, 1 bit: program-memory write strobe.
REQ-010 SHALL have port run_en, input, 1 bit: free-run enable.
REQ-011 SHALL have port halt_req, input, 1 bit: request halt at the next instruction boundary.
REQ-012 SHALL have port step_req, input, 1 bit: execute exactly one instruction while halted.
REQ-013 SHALL have port restart_req, input, 1 bit: return to LOAD from HALT.
REQ-014 SHALL have port stage, output, 2 bits: processor stage to the control unit (00 LOAD, 01 FETCH, 10 DECODE, 11 EXECUTE).
REQ-015 SHALL have port core_en, output, 1 bit: high only in FETCH, DECODE and EXECUTE; the integrator ANDs it into all control-unit enables.
REQ-016 SHALL have port halted, output, 1 bit: sequencer is in HALT.
REQ-017 SHALL have port instr_count, output, 16 bits: count of completed EXECUTE cycles.

Function
REQ-018 SHALL implement the states LOAD, FETCH, DECODE, EXECUTE and HALT; stage SHALL equal LOAD's code in LOAD and HALT, and the state's code otherwise.
REQ-019 SHALL hold load_ready high only in LOAD; a word SHALL be accepted when load_valid and load_ready are both high.
REQ-020 SHALL drive pmem_we = load_valid & load_ready combinationally, with pmem_addr equal to the current load address and pmem_wdata = load_data.
REQ-021 SHALL increment the load address by 1 after each accepted word.
REQ-022 SHALL end loading when the accepted word has load_last=1 or was written at address 255; the next state SHALL be FETCH if run_en=1, else HALT.
REQ-023 SHALL not wrap the load address; an accept at 255 SHALL terminate LOAD even without load_last.
REQ-024 SHALL, when running, advance FETCH->DECODE->EXECUTE->FETCH one state per clock, giving 3 cycles per instruction.
REQ-025 SHALL evaluate halt_req and run_en only in EXECUTE: if halt_req=1 or run_en=0, the next state SHALL be HALT, else FETCH; the current instruction always completes.
REQ-026 SHALL ignore halt_req and step_req in FETCH and DECODE; both are level-sampled, not latched.
REQ-027 SHALL, in HALT, prioritise restart_req over step_req over run_en:
  - restart_req -> LOAD, load address cleared to 0;
  - else step_req -> FETCH in single-step mode;
  - else run_en=1 and halt_req=0 -> FETCH in free-run mode;
  - else stay in HALT.
REQ-028 SHALL, in single-step mode, always go EXECUTE->HALT regardless of run_en; the mode flag SHALL clear on re-entering HALT.
REQ-029 SHALL increment instr_count by 1 on every clock spent in EXECUTE, wrapping from 0xFFFF to 0x0000, and SHALL clear it on restart_req acceptance.
REQ-030 SHALL assert halted combinationally from the state register, with no added latency.

Reset
REQ-031 SHALL, when rst=1 at a clock edge, set state=LOAD, load address=0, single-step flag=0 and instr_count=0, overriding all other inputs, including mid-load and mid-instruction.
REQ-032 SHALL, after reset, present stage=00, load_ready=1, pmem_we=0 (while load_valid=0), core_en=0 and halted=0.

Structure
REQ-033 SHALL take the stage encodings (LOAD/FETCH/DECODE/EXECUTE), the HALT state encoding, the 8-bit program address width and the 12-bit instruction width from a shared package, shared with the control unit.
REQ-034 SHALL contain one sub-module, load_addr_counter: an 8-bit counter with clear, increment and a terminal-count flag at 255.

Verification
REQ-035 SHALL cover: reset, then 3 words with load_last on the third -> pmem_we pulses at addresses 0,1,2, then FETCH on the next cycle (run_en=1).
REQ-036 SHALL cover: 256 words without load_last -> the last write is at address 255, then FETCH; load_ready=0 thereafter.
REQ-037 SHALL cover: free-run, halt_req asserted during DECODE of instruction 2 -> EXECUTE completes, then HALT with instr_count=2.
REQ-038 SHALL cover: in HALT, a one-cycle step_req with run_en=1 -> exactly FETCH, DECODE, EXECUTE, HALT, with instr_count +1.
REQ-039 SHALL cover: in HALT, step_req and restart_req both high -> LOAD, instr_count=0, load address=0.
REQ-040 SHALL cover: rst asserted during the 2nd accepted load word and during EXECUTE -> LOAD with address 0 on the next cycle.
